// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer for m^e mod n.
// Drives an external multi-cycle modular multiplier (fixed latency CC) and
// walks all N exponent bits, so run time depends only on popcount(e).
module modexp_ctrl #(
    parameter int N  = 8,
    parameter int CC = N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] m,
    input  logic [N-1:0] e,
    input  logic [N-1:0] n,
    output logic [N-1:0] o,
    output logic         busy,
    output logic         done,
    output logic         mm_start,
    output logic [N-1:0] mm_x,
    output logic [N-1:0] mm_y,
    output logic [N-1:0] mm_n,
    input  logic [N-1:0] mm_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (CC > 1) ? $clog2(CC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   e_q, e_d;
    logic [N-1:0]   n_q, n_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   o_q, o_d;
    logic [IW-1:0]  i_q, i_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           wait_last;
    logic           advance;

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            r_q     <= N'(1);
            o_q     <= '0;
            i_q     <= IW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            n_q     <= n_d;
            r_q     <= r_d;
            o_q     <= o_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: sequence squares and conditional multiplies per bit.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        e_d       = e_q;
        n_d       = n_q;
        r_d       = r_q;
        o_d       = o_q;
        i_d       = i_q;
        cnt_d     = cnt_q;
        wait_last = (cnt_q == CW'(CC - 1));
        advance   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = m;
                    e_d     = e;
                    n_d     = n;
                    r_d     = N'(1);
                    i_d     = IW'(N - 1);
                    cnt_d   = '0;
                    state_d = SQ_ISSUE;
                end
            end
            SQ_ISSUE: begin
                cnt_d   = '0;
                state_d = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (wait_last) begin
                    r_d   = mm_o;
                    cnt_d = '0;
                    if (e_q[i_q]) begin
                        state_d = MUL_ISSUE;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MUL_ISSUE: begin
                cnt_d   = '0;
                state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (wait_last) begin
                    r_d     = mm_o;
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The final product is taken straight from the multiplier so o is
        // valid on the very edge that enters DONE.
        if (advance) begin
            if (i_q == '0) begin
                o_d     = mm_o;
                state_d = DONE;
            end else begin
                i_d     = i_q - IW'(1);
                state_d = SQ_ISSUE;
            end
        end
    end

    // Outputs decoded from state; operands stay put from ISSUE through WAIT.
    always_comb begin
        o        = o_q;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        mm_start = (state_q == SQ_ISSUE) || (state_q == MUL_ISSUE);
        mm_x     = r_q;
        mm_y     = ((state_q == MUL_ISSUE) || (state_q == MUL_WAIT)) ? m_q : r_q;
        mm_n     = n_q;
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: fixed-latency modmult model plus a plain
// repeated-multiplication reference for m^e mod n and closed-form timing.
module tb_modexp_ctrl;

    localparam int N  = 8;
    localparam int CC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] m, e, n;
    logic [N-1:0] o;
    logic         busy, done, mm_start;
    logic [N-1:0] mm_x, mm_y, mm_n, mm_o;

    int errors = 0;
    int checks = 0;

    modexp_ctrl #(.N(N), .CC(CC)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .e        (e),
        .n        (n),
        .o        (o),
        .busy     (busy),
        .done     (done),
        .mm_start (mm_start),
        .mm_x     (mm_x),
        .mm_y     (mm_y),
        .mm_n     (mm_n),
        .mm_o     (mm_o)
    );

    always #5 clk = ~clk;

    // Modmult model: result valid only on the CC-th edge after the start edge,
    // random garbage otherwise so an early or late capture is visible.
    logic [N-1:0] mm_res;
    logic [N-1:0] mm_garb = '0;
    int           mm_left;
    bit           mm_pend;

    always @(posedge clk) mm_garb <= N'($urandom);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mm_pend <= 1'b0;
            mm_left <= 0;
            mm_res  <= '0;
        end else if (mm_start) begin
            mm_pend <= 1'b1;
            mm_left <= CC - 1;
            mm_res  <= (mm_n == 0) ? '0 : N'((int'(mm_x) * int'(mm_y)) % int'(mm_n));
        end else if (mm_left > 0) begin
            mm_left <= mm_left - 1;
        end
    end

    assign mm_o = (mm_pend && mm_left == 0) ? mm_res : mm_garb;

    // Reference: multiply by m, e times, reducing each step.
    function automatic int ref_pow(input int mb, input int eb, input int nb);
        int r;
        r = 1 % nb;
        for (int k = 0; k < eb; k++) r = (r * mb) % nb;
        return r;
    endfunction

    function automatic int ref_lat(input logic [N-1:0] eb);
        return (N + $countones(eb)) * (CC + 1);
    endfunction

    // Waits for IDLE, presents operands with start, returns just after edge T0.
    task automatic launch(input logic [N-1:0] mi, input logic [N-1:0] ei,
                          input logic [N-1:0] ni, input bit hold);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 4000) begin
            @(negedge clk);
            g++;
        end
        m = mi;
        e = ei;
        n = ni;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Counts edges from T0 to done; returns at the negedge inside DONE.
    task automatic measure(input bit perturb, output int lat, output int pulses,
                           output int busy_low);
        int cnt;
        cnt = 0;
        lat = -1;
        pulses = 0;
        busy_low = 0;
        while (1) begin
            @(negedge clk);
            if (mm_start) pulses++;
            if (!busy) busy_low++;
            if (done) begin
                lat = cnt;
                break;
            end
            if (cnt > 4000) break;
            if (perturb) begin
                start = 1'($urandom_range(0, 1));
                m = N'($urandom);
                e = N'($urandom);
                n = N'($urandom);
            end
            @(posedge clk);
            cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        m = '0;
        e = '0;
        n = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_o got=%0d want=0", o); end
        checks++;
        if (mm_start !== 1'b0) begin errors++; $display("FAIL reset_mm_start got=%b want=0", mm_start); end
        $display("reset: busy=%b done=%b o=%0d mm_start=%b", busy, done, o, mm_start);
        rst = 1'b1;
    endtask

    task automatic test_vectors;
        logic [N-1:0] vm [3] = '{8'd45, 8'd45, 8'd37};
        logic [N-1:0] ve [3] = '{8'd5, 8'd0, 8'hFF};
        logic [N-1:0] vn [3] = '{8'd107, 8'd107, 8'd107};
        int lat, pulses, busy_low;
        logic [N-1:0] exp_o, held;
        for (int k = 0; k < 3; k++) begin
            exp_o = N'(ref_pow(vm[k], ve[k], vn[k]));
            launch(vm[k], ve[k], vn[k], 1'b0);
            measure(1'b0, lat, pulses, busy_low);
            checks++;
            if (o !== exp_o) begin errors++; $display("FAIL vec%0d_o got=%0d want=%0d", k, o, exp_o); end
            checks++;
            if (lat != ref_lat(ve[k])) begin errors++; $display("FAIL vec%0d_latency got=%0d want=%0d", k, lat, ref_lat(ve[k])); end
            checks++;
            if (pulses != N + $countones(ve[k])) begin errors++; $display("FAIL vec%0d_pulses got=%0d want=%0d", k, pulses, N + $countones(ve[k])); end
            checks++;
            if (busy_low != 0) begin errors++; $display("FAIL vec%0d_busy low_cycles=%0d want=0", k, busy_low); end
            held = o;
            repeat (3) @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL vec%0d_done_width got=%b want=0", k, done); end
            checks++;
            if (o !== exp_o) begin errors++; $display("FAIL vec%0d_o_hold got=%0d want=%0d", k, o, exp_o); end
            $display("vector m=%0d e=%0d n=%0d: o=%0d (exp %0d) latency=%0d pulses=%0d held=%0d",
                     vm[k], ve[k], vn[k], o, exp_o, lat, pulses, held);
        end
    endtask

    task automatic test_random;
        int lat, pulses, busy_low;
        logic [N-1:0] rm, re, rn, exp_o;
        for (int k = 0; k < 8; k++) begin
            rn = N'($urandom_range(2, 255));
            rm = N'($urandom_range(0, int'(rn) - 1));
            re = N'($urandom);
            exp_o = N'(ref_pow(rm, re, rn));
            launch(rm, re, rn, 1'b0);
            measure(1'b0, lat, pulses, busy_low);
            checks++;
            if (o !== exp_o) begin errors++; $display("FAIL rand%0d_o got=%0d want=%0d", k, o, exp_o); end
            checks++;
            if (lat != ref_lat(re)) begin errors++; $display("FAIL rand%0d_latency got=%0d want=%0d", k, lat, ref_lat(re)); end
            $display("random m=%0d e=%0d n=%0d: o=%0d (exp %0d) latency=%0d", rm, re, rn, o, exp_o, lat);
        end
    endtask

    task automatic test_ignore_start;
        int lat, pulses, busy_low;
        launch(8'd45, 8'd5, 8'd107, 1'b0);
        measure(1'b1, lat, pulses, busy_low);
        start = 1'b0;
        checks++;
        if (o !== 8'd98) begin errors++; $display("FAIL ignore_o got=%0d want=98", o); end
        checks++;
        if (lat != 90) begin errors++; $display("FAIL ignore_latency got=%0d want=90", lat); end
        checks++;
        if (pulses != 10) begin errors++; $display("FAIL ignore_pulses got=%0d want=10", pulses); end
        $display("ignore-start: o=%0d latency=%0d pulses=%0d", o, lat, pulses);
    endtask

    task automatic test_reset_mid;
        int lat, pulses, busy_low, done_seen;
        launch(8'd45, 8'd5, 8'd107, 1'b0);
        repeat (39) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++;
        if (o !== '0) begin errors++; $display("FAIL rstmid_o got=%0d want=0", o); end
        checks++;
        if (mm_start !== 1'b0) begin errors++; $display("FAIL rstmid_mm_start got=%b want=0", mm_start); end
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL rstmid_quiet active_cycles=%0d want=0", done_seen); end
        rst = 1'b1;
        launch(8'd45, 8'd5, 8'd107, 1'b0);
        measure(1'b0, lat, pulses, busy_low);
        checks++;
        if (o !== 8'd98) begin errors++; $display("FAIL rstmid_rerun_o got=%0d want=98", o); end
        checks++;
        if (lat != 90) begin errors++; $display("FAIL rstmid_rerun_latency got=%0d want=90", lat); end
        $display("reset-mid-run: rerun o=%0d latency=%0d", o, lat);
    endtask

    task automatic test_back_to_back;
        int lat, pulses, busy_low;
        logic [N-1:0] m2, e2, exp2;
        m2 = N'($urandom_range(0, 106));
        e2 = N'($urandom);
        exp2 = N'(ref_pow(m2, e2, 107));
        launch(8'd45, 8'd5, 8'd107, 1'b1);
        measure(1'b0, lat, pulses, busy_low);
        checks++;
        if (o !== 8'd98) begin errors++; $display("FAIL b2b_first_o got=%0d want=98", o); end
        checks++;
        if (lat != 90) begin errors++; $display("FAIL b2b_first_latency got=%0d want=90", lat); end
        $display("back-to-back run1: o=%0d latency=%0d", o, lat);
        m = m2;
        e = e2;
        n = 8'd107;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy got=%b want=0", busy); end
        @(posedge clk);
        #1;
        measure(1'b0, lat, pulses, busy_low);
        start = 1'b0;
        checks++;
        if (o !== exp2) begin errors++; $display("FAIL b2b_second_o got=%0d want=%0d", o, exp2); end
        checks++;
        if (lat != ref_lat(e2)) begin errors++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, ref_lat(e2)); end
        $display("back-to-back run2 m=%0d e=%0d: o=%0d (exp %0d) latency=%0d", m2, e2, o, exp2, lat);
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: operand/modulus width in bits.
REQ-002 SHALL have parameter CC, default N: modmult latency in cycles, start-sample edge to result-valid edge.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled high in IDLE begins an exponentiation.
REQ-006 SHALL have port m  input  N  base.
REQ-007 SHALL have port e  input  N  exponent.
REQ-008 SHALL have port n  input  N  modulus.
REQ-009 SHALL have port o  output  N  result m^e mod n.
REQ-010 SHALL have port busy  output  1  high while an exponentiation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when o becomes valid.
REQ-012 SHALL have port mm_start  output  1  start pulse to the shared modmult datapath.
REQ-013 SHALL have ports mm_x, mm_y, mm_n  output  N each  modmult operands.
REQ-014 SHALL have port mm_o  input  N  modmult result.

Function
REQ-015 SHALL implement states IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
REQ-016 SHALL, in IDLE with start=1 at edge T0, latch m, e, n into internal registers; set r=1; set bit index i=N-1; enter SQ_ISSUE.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL keep latched operands stable for the whole run; later changes on m/e/n have no effect.
REQ-019 SHALL compute left-to-right square-and-multiply: for i=N-1 downto 0, r=r*r mod n, then r=r*m mod n if e[i]=1.
REQ-020 SHALL process all N exponent bits, leading zeros included; latency depends only on popcount(e).
REQ-021 SHALL hold each *_ISSUE state exactly 1 cycle with mm_start=1; mm_start SHALL be 0 in all other states.
REQ-022 SHALL hold each *_WAIT state exactly CC cycles, counted by a wait counter, and capture mm_o into r on the CC-th edge in WAIT.
REQ-023 SHALL drive mm_x=r, mm_y=r in SQ_ISSUE/SQ_WAIT; mm_x=r, mm_y=latched m in MUL_ISSUE/MUL_WAIT; mm_n=latched n at all times; operands stable from ISSUE through the end of WAIT.
REQ-024 SHALL, after SQ_WAIT, go to MUL_ISSUE if e[i]=1, else advance i; after MUL_WAIT, advance i.
REQ-025 SHALL, on advance with i=0, enter DONE; otherwise decrement i and enter SQ_ISSUE.
REQ-026 SHALL load o=r on the edge entering DONE; assert done=1 for exactly the DONE cycle; return to IDLE on the next edge.
REQ-027 SHALL hold o unchanged from DONE until the next completed run.
REQ-028 SHALL drive busy=1 in every state except IDLE; busy SHALL also be 1 during DONE.
REQ-029 SHALL enter DONE on edge T0 + K*(CC+1), where K = N + popcount(e).
REQ-030 SHALL accept a new start on the first cycle back in IDLE (back-to-back runs).
REQ-031 SHALL still run with full latency and pulse done when n<=1 or m>=n; o is then unspecified.

Reset
REQ-032 SHALL, while rst=0, immediately force state=IDLE, o=0, done=0, busy=0, mm_start=0, r=1, i=N-1, wait counter=0, regardless of clk.
REQ-033 SHALL abandon any run in progress on reset mid-operation, with no done pulse; the first start after rst returns to 1 SHALL run normally.

Verification
REQ-034 SHALL pass: N=8, CC=8, m=45, e=5, n=107, with a reference modmult model -> K=10, done at T0+90, o=98, exactly 10 mm_start pulses.
REQ-035 SHALL pass: m=45, e=0, n=107 -> K=8, done at T0+72, o=1, 8 squares only.
REQ-036 SHALL pass: m=37, e=0xFF, n=107 -> K=16, done at T0+144, o=37^255 mod 107 from the bench model.
REQ-037 SHALL pass: start re-pulsed and m/e/n changed mid-run -> ignored, original result and timing unchanged.
REQ-038 SHALL pass: rst=0 asserted at T0+40 of the e=5 run -> outputs zero immediately, no done; a new run with e=5 -> o=98 at T0'+90.
REQ-039 SHALL pass: back-to-back runs with start held high -> second run begins the cycle after done, both results correct.
